// File: rtl/regfile_wr_arb.sv
// Regfile write arbiter: port A writes combinationally with priority, port B is buffered
// (DEPTH entries, >=1 cycle latency, b_ready from registered count only); WR_FWD_EN enables pend_data forwarding.
module regfile_wr_arb #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_we,
  input  logic [4:0]  a_waddr,
  input  logic [31:0] a_wdata,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_waddr,
  input  logic [31:0] b_wdata,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  input  logic [4:0]  qaddr1,
  input  logic [4:0]  qaddr2,
  output logic        pend1,
  output logic        pend2,
  output logic [31:0] pend_data1,
  output logic [31:0] pend_data2,
  output logic [2:0]  count
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;

  logic [4:0]    addr_q [DEPTH];
  logic [4:0]    addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic          vld_q  [DEPTH];
  logic          vld_d  [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [2:0]    count_q, count_d;

  logic a_act, push, pop;

  always_comb begin
    a_act   = a_we && (a_waddr != 5'd0);
    b_ready = (count_q < 3'(DEPTH));
    push    = b_valid && b_ready && (b_waddr != 5'd0);
    pop     = !a_act && (count_q != 3'd0);

    we    = 1'b0;
    waddr = 5'd0;
    wdata = 32'd0;
    if (a_act) begin
      we    = 1'b1;
      waddr = a_waddr;
      wdata = a_wdata;
    end else if (pop && vld_q[head_q]) begin
      we    = 1'b1;
      waddr = addr_q[head_q];
      wdata = data_q[head_q];
    end

    addr_d  = addr_q;
    data_d  = data_q;
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + 3'(push) - 3'(pop);

    // A is younger than anything already buffered, so it kills matching entries;
    // the push below runs after this so a same-cycle B entry survives.
    for (int i = 0; i < DEPTH; i++) begin
      if (a_act && (addr_q[i] == a_waddr)) vld_d[i] = 1'b0;
      if (pop && (PW'(i) == head_q)) vld_d[i] = 1'b0;
      if (push && (PW'(i) == tail_q)) begin
        addr_d[i] = b_waddr;
        data_d[i] = b_wdata;
        vld_d[i]  = 1'b1;
      end
    end
    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
        vld_q[i]  <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 3'd0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

  logic [4:0]    q_addr   [2];
  logic          hit      [2];
  logic [31:0]   hit_data [2];
  logic [PW-1:0] idx;

  // Scan oldest to youngest so the last match is the youngest; popped slots are invalid.
  always_comb begin
    q_addr[0] = qaddr1;
    q_addr[1] = qaddr2;
    idx       = '0;
    for (int q = 0; q < 2; q++) begin
      hit[q]      = 1'b0;
      hit_data[q] = 32'd0;
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_q + PW'(k);
        if ((q_addr[q] != 5'd0) && vld_q[idx] && (addr_q[idx] == q_addr[q])) begin
          hit[q] = 1'b1;
`ifdef WR_FWD_EN
          hit_data[q] = data_q[idx];
`else
          hit_data[q] = 32'd0;
`endif
        end
      end
    end
  end

  assign pend1      = hit[0];
  assign pend2      = hit[1];
  assign pend_data1 = hit_data[0];
  assign pend_data2 = hit_data[1];

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed bench for regfile_wr_arb (DEPTH=2), forwarding expectations follow WR_FWD_EN.
module tb_regfile_wr_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_we = 1'b0;
  logic [4:0]  a_waddr = 5'd0;
  logic [31:0] a_wdata = 32'd0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [4:0]  b_waddr = 5'd0;
  logic [31:0] b_wdata = 32'd0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  qaddr1 = 5'd0;
  logic [4:0]  qaddr2 = 5'd0;
  logic        pend1, pend2;
  logic [31:0] pend_data1, pend_data2;
  logic [2:0]  count;

  int total = 0;
  int fails = 0;
  logic [31:0] rf [32];

  regfile_wr_arb #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .qaddr1(qaddr1), .qaddr2(qaddr2),
    .pend1(pend1), .pend2(pend2), .pend_data1(pend_data1), .pend_data2(pend_data2),
    .count(count)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) rf[i] = 32'd0;
  always @(posedge clk) if (we) rf[waddr] <= wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                     input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    a_we = aw; a_waddr = aa; a_wdata = ad;
    b_valid = bv; b_waddr = ba; b_wdata = bd;
    #1;
  endtask

  logic [31:0] exp_fwd2, exp_fwd1;

  initial begin
`ifdef WR_FWD_EN
    exp_fwd2 = 32'hBEEF;
    exp_fwd1 = 32'h66;
`else
    exp_fwd2 = 32'd0;
    exp_fwd1 = 32'd0;
`endif
    // reset state
    #2;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pend1", 32'(pend1), 32'd0);
    chk("rst_pdata2", pend_data2, 32'd0);
    cyc(); cyc();
    #2 rst = 1'b0;
    cyc();
    chk("rst_bready", 32'(b_ready), 32'd1);

    // B single write, A idle
    drv(0, 5'd0, 32'd0, 1, 5'd5, 32'h1234);
    chk("s35_bready", 32'(b_ready), 32'd1);
    chk("s35_we_pre", 32'(we), 32'd0);
    cyc();
    drv(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("s35_count1", 32'(count), 32'd1);
    chk("s35_we", 32'(we), 32'd1);
    chk("s35_waddr", 32'(waddr), 32'd5);
    chk("s35_wdata", wdata, 32'h1234);
    cyc();
    chk("s35_count0", 32'(count), 32'd0);
    chk("s35_we_post", 32'(we), 32'd0);

    // A continuous with B queueing r7 then r8
    drv(1, 5'd3, 32'hAAAA, 1, 5'd7, 32'h77);
    chk("s36_waddr_a", 32'(waddr), 32'd3);
    cyc();
    drv(1, 5'd3, 32'hAAAA, 1, 5'd8, 32'h88);
    chk("s36_count1", 32'(count), 32'd1);
    chk("s36_bready1", 32'(b_ready), 32'd1);
    cyc();
    drv(1, 5'd3, 32'hAAAA, 1, 5'd10, 32'h10);
    chk("s36_count2", 32'(count), 32'd2);
    chk("s36_bready0", 32'(b_ready), 32'd0);
    chk("s36_we_a", 32'(we), 32'd1);
    chk("s36_waddr_a2", 32'(waddr), 32'd3);
    chk("s36_wdata_a", wdata, 32'hAAAA);
    cyc();
    drv(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("s36_full_hold", 32'(count), 32'd2);
    chk("s36_waddr_r7", 32'(waddr), 32'd7);
    chk("s36_wdata_r7", wdata, 32'h77);
    cyc();
    chk("s36_count_r8", 32'(count), 32'd1);
    chk("s36_waddr_r8", 32'(waddr), 32'd8);
    chk("s36_wdata_r8", wdata, 32'h88);
    cyc();
    chk("s36_empty", 32'(count), 32'd0);
    chk("s36_we_idle", 32'(we), 32'd0);

    // A write kills an older buffered B write to the same register
    drv(0, 5'd0, 32'd0, 1, 5'd9, 32'h1);
    cyc();
    qaddr1 = 5'd9;
    drv(1, 5'd9, 32'h2, 0, 5'd0, 32'd0);
    chk("s37_pend_on", 32'(pend1), 32'd1);
    chk("s37_count", 32'(count), 32'd1);
    chk("s37_wdata_a", wdata, 32'h2);
    cyc();
    drv(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("s37_pend_off", 32'(pend1), 32'd0);
    chk("s37_count_h", 32'(count), 32'd1);
    chk("s37_pop_we0", 32'(we), 32'd0);
    cyc();
    chk("s37_count0", 32'(count), 32'd0);
    chk("s37_rf9", rf[9], 32'h2);
    qaddr1 = 5'd0;

    // zero-address requests on both ports
    drv(1, 5'd0, 32'hFFFF, 1, 5'd0, 32'hDEAD);
    chk("s38_we", 32'(we), 32'd0);
    chk("s38_waddr", 32'(waddr), 32'd0);
    chk("s38_wdata", wdata, 32'd0);
    chk("s38_bready", 32'(b_ready), 32'd1);
    cyc();
    drv(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("s38_count", 32'(count), 32'd0);

    // r4 buffered behind a head stalled by A traffic
    drv(1, 5'd1, 32'h11, 1, 5'd6, 32'h66);
    cyc();
    drv(1, 5'd1, 32'h11, 1, 5'd4, 32'hBEEF);
    cyc();
    qaddr1 = 5'd6;
    qaddr2 = 5'd4;
    drv(1, 5'd1, 32'h11, 0, 5'd0, 32'd0);
    chk("s39_count", 32'(count), 32'd2);
    chk("s39_pend2", 32'(pend2), 32'd1);
    chk("s39_pdata2", pend_data2, exp_fwd2);
    chk("s39_pend1", 32'(pend1), 32'd1);
    chk("s39_pdata1", pend_data1, exp_fwd1);

    // asynchronous reset with two entries buffered
    a_we = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("s40_count_async", 32'(count), 32'd0);
    chk("s40_we_async", 32'(we), 32'd0);
    chk("s40_pend2_async", 32'(pend2), 32'd0);
    #1 rst = 1'b0;
    cyc();
    chk("s40_we1", 32'(we), 32'd0);
    chk("s40_bready", 32'(b_ready), 32'd1);
    chk("s40_count1", 32'(count), 32'd0);
    cyc();
    chk("s40_we2", 32'(we), 32'd0);
    chk("s40_rf6", rf[6], 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arb.md
REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffer entries for port B (legal: 2 or 4).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port a_we, input, 1 bit: pipeline writeback request; a non-stallable requester.
REQ-005 SHALL have ports a_waddr (input, 5 bits) and a_wdata (input, 32 bits): port A destination and data.
REQ-006 SHALL have port b_valid, input, 1 bit: multi-cycle unit write request.
REQ-007 SHALL have port b_ready, output, 1 bit: port B accept.
REQ-008 SHALL have ports b_waddr (input, 5 bits) and b_wdata (input, 32 bits): port B destination and data.
REQ-009 SHALL have ports we (output, 1 bit), waddr (output, 5 bits) and wdata (output, 32 bits): the regfile write port.
REQ-010 SHALL have ports qaddr1 and qaddr2, input, 5 bits each: decode hazard query addresses.
REQ-011 SHALL have ports pend1 and pend2, output, 1 bit each: the queried register has a valid buffered write.
REQ-012 SHALL have ports pend_data1 and pend_data2, output, 32 bits each: forwarded pending data.
REQ-013 SHALL have port count, output, 3 bits: number of occupied buffer entries.

Function
REQ-014 Port A SHALL take priority: a_we=1 with a_waddr!=0 drives we=1, waddr=a_waddr and wdata=a_wdata combinationally in the same cycle.
REQ-015 a_we=1 with a_waddr=0 SHALL be treated as port A idle.
REQ-016 b_ready SHALL equal (count<DEPTH); it SHALL depend only on registered state, with no pass-through when full.
REQ-017 A handshake (b_valid and b_ready) with b_waddr!=0 SHALL enqueue {addr, data, valid=1} at the tail.
REQ-018 A handshake with b_waddr=0 SHALL be accepted and discarded, with count unchanged.
REQ-019 When port A is idle and the buffer is non-empty, the head SHALL be popped in that cycle.
REQ-020 A popped head with valid=1 SHALL drive we/waddr/wdata from the head.
REQ-021 A popped head with valid=0 SHALL be discarded with we=0.
REQ-022 Minimum B latency SHALL be one cycle: enqueue at edge N, earliest regfile write in cycle N+1.
REQ-023 Buffer order SHALL be FIFO; pointers wrap modulo DEPTH.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged.
REQ-025 Ordering: a port A write to address r SHALL clear valid on every buffered entry with addr==r at that edge, because A is younger.
REQ-026 An entry enqueued in the same cycle as a matching port A write SHALL be stored valid, because B is younger.
REQ-027 pendN SHALL be 1 iff qaddrN!=0 and some buffered entry has valid=1 and addr==qaddrN; pendN is combinational.
REQ-028 When no write source is selected, the outputs SHALL be we=0, waddr=0 and wdata=0.

Reset
REQ-029 rst=1 SHALL asynchronously clear all valid bits, the head and tail pointers, and count.
REQ-030 During and after reset, outputs SHALL be: we=0, waddr=0, wdata=0, pend1/2=0, pend_data1/2=0, count=0, b_ready=1 after reset release.
REQ-031 Reset mid-operation SHALL drop all buffered writes; no regfile write occurs for them.

Configuration
REQ-032 Macro WR_FWD_EN SHALL select the forwarding behaviour.
REQ-033 With WR_FWD_EN defined, pend_dataN SHALL be the data of the youngest valid matching entry when pendN=1, else 0.
REQ-034 Without WR_FWD_EN, pend_data1/2 SHALL be tied to 0 and pendN behaviour SHALL be unchanged.

Verification
REQ-035 Scenario: B writes r5=0x1234 with A idle. Required: b_ready=1, count=1 after the edge, then next cycle we=1, waddr=5, wdata=0x1234, and count returns to 0.
REQ-036 Scenario: A writes r3=0xAAAA continuously while B enqueues r7 and then r8. Required: count=2, b_ready=0, we shows only r3; when A drops, r7 is written and then r8 on consecutive cycles.
REQ-037 Scenario: B buffers r9=0x1, then A writes r9=0x2. Required: pend with qaddr1=9 goes 1 then 0; the buffered entry pops with we=0; the final regfile value is 0x2.
REQ-038 Scenario: B handshakes b_waddr=0, and separately A has a_we=1 with a_waddr=0. Required: count unchanged and we=0.
REQ-039 Scenario: WR_FWD_EN defined, r4=0xBEEF buffered behind a stalled head, qaddr2=4. Required: pend2=1 and pend_data2=0xBEEF. Same stimulus without the macro: pend_data2=0.
REQ-040 Scenario: rst pulsed with count=2. Required: count=0 immediately (asynchronous), no subsequent we, and b_ready=1.
